// File: rtl/k6502_regs.sv
// k6502 architectural registers A/X/Y/S and status register P.
// Captures ALU results and flags; feeds the operands back to the ALU.
module k6502_regs #(
  parameter logic [7:0] SP_RESET = 8'hFD,
  parameter logic [7:0] P_RESET  = 8'h24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] alu_data,
  input  logic [7:0] alu_sr,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [7:0] flag_mask,
  input  logic [7:0] flag_set,
  input  logic [7:0] flag_clr,
  input  logic       plp_en,
  input  logic       sp_inc,
  input  logic       sp_dec,
  output logic [7:0] reg_a,
  output logic [7:0] reg_x,
  output logic [7:0] reg_y,
  output logic [7:0] reg_s,
  output logic [7:0] sr,
  output logic [7:0] sr_push
);

  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    SEL_X = 2'b01,
    SEL_Y = 2'b10,
    SEL_S = 2'b11
  } sel_t;

  sel_t       sel;
  logic [7:0] a, x, y, s, p;
  logic [7:0] p_next, s_next;

  assign sel = sel_t'(wr_sel);

  always_comb begin
    p_next = p;
    for (int unsigned i = 0; i < 8; i++) begin
      if (plp_en)            p_next[i] = alu_data[i];
      else if (flag_clr[i])  p_next[i] = 1'b0;
      else if (flag_set[i])  p_next[i] = 1'b1;
      else if (flag_mask[i]) p_next[i] = alu_sr[i];
    end
    // bit5 is hardwired high and B (bit4) only exists in the pushed image
    p_next[5] = 1'b1;
    p_next[4] = 1'b0;
  end

  always_comb begin
    s_next = s;
    if (sp_inc && !sp_dec)      s_next = s + 8'd1;
    else if (sp_dec && !sp_inc) s_next = s - 8'd1;
    if (wr_en && sel == SEL_S)  s_next = alu_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a <= '0;
      x <= '0;
      y <= '0;
      s <= SP_RESET;
      p <= (P_RESET | 8'h20) & 8'hEF;
    end else begin
      if (wr_en) begin
        case (sel)
          SEL_A:   a <= alu_data;
          SEL_X:   x <= alu_data;
          SEL_Y:   y <= alu_data;
          default: ;
        endcase
      end
      s <= s_next;
      p <= p_next;
    end
  end

  assign reg_a   = a;
  assign reg_x   = x;
  assign reg_y   = y;
  assign reg_s   = s;
  assign sr      = p;
  assign sr_push = p | 8'h30;

endmodule

// File: tb/tb_k6502_regs.sv
// Self-checking bench for k6502_regs: directed cases plus randomized cycles
// checked against an arithmetic reference model.
module tb_k6502_regs;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] alu_data, alu_sr, flag_mask, flag_set, flag_clr;
  logic       wr_en, plp_en, sp_inc, sp_dec;
  logic [1:0] wr_sel;
  logic [7:0] reg_a, reg_x, reg_y, reg_s, sr, sr_push;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // reference state: regs[0..3] = A, X, Y, S
  logic [7:0] m_regs [4];
  logic [7:0] m_p;

  k6502_regs #(.SP_RESET(8'hFD), .P_RESET(8'h24)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_data(alu_data), .alu_sr(alu_sr),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .flag_mask(flag_mask), .flag_set(flag_set), .flag_clr(flag_clr),
    .plp_en(plp_en), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y), .reg_s(reg_s),
    .sr(sr), .sr_push(sr_push)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    alu_data = '0; alu_sr = '0; wr_en = 0; wr_sel = '0;
    flag_mask = '0; flag_set = '0; flag_clr = '0;
    plp_en = 0; sp_inc = 0; sp_dec = 0;
  endtask

  task automatic model_reset();
    m_regs[0] = 8'h00; m_regs[1] = 8'h00; m_regs[2] = 8'h00;
    m_regs[3] = 8'hFD; m_p = 8'h24;
  endtask

  task automatic model_step();
    logic [7:0] np;
    int sp;
    sp = (int'(m_regs[3]) + int'(sp_inc) - int'(sp_dec) + 256) % 256;
    m_regs[3] = 8'(sp);
    if (wr_en) m_regs[wr_sel] = alu_data;
    if (plp_en) np = alu_data;
    else np = (((m_p & ~flag_mask) | (alu_sr & flag_mask)) | flag_set) & ~flag_clr;
    m_p = (np | 8'h20) & 8'hEF;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a"},    reg_a,   m_regs[0]);
    check({tag, ".x"},    reg_x,   m_regs[1]);
    check({tag, ".y"},    reg_y,   m_regs[2]);
    check({tag, ".s"},    reg_s,   m_regs[3]);
    check({tag, ".sr"},   sr,      m_p);
    check({tag, ".push"}, sr_push, m_p | 8'h30);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    idle();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    model_reset();
    #12;
    reset_n = 1'b1;
    @(posedge clk); #1;
    idle();

    // async reset mid-cycle while a write is pending
    wr_en = 1; wr_sel = 2'b00; alu_data = 8'h77;
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst.a", reg_a, 8'h00);
    check("rst.s", reg_s, 8'hFD);
    check("rst.sr", sr, 8'h24);
    check("rst.push", sr_push, 8'h34);
    check_all("rst");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst.nowrite", reg_a, 8'h00);
    tick("rst.firstwr");
    check("rst.firstwr.val", reg_a, 8'h77);

    // write X, others unchanged
    wr_en = 1; wr_sel = 2'b01; alu_data = 8'h5A;
    tick("wrx");
    check("wrx.val", reg_x, 8'h5A);
    // TXS beats sp_dec
    wr_en = 1; wr_sel = 2'b11; alu_data = 8'hFF; sp_dec = 1;
    tick("txs");
    check("txs.val", reg_s, 8'hFF);

    // stack pointer wrap
    wr_en = 1; wr_sel = 2'b11; alu_data = 8'h00;
    tick("s0");
    sp_dec = 1; tick("sdec");
    check("sdec.wrap", reg_s, 8'hFF);
    sp_inc = 1; tick("sinc");
    check("sinc.wrap", reg_s, 8'h00);
    sp_inc = 1; sp_dec = 1; tick("sboth");
    check("sboth.hold", reg_s, 8'h00);

    // flag mask
    alu_sr = 8'hC3; flag_mask = 8'h82; tick("mask1");
    check("mask1.val", sr, 8'hA6);
    alu_sr = 8'h00; flag_mask = 8'hC3; tick("mask2");
    check("mask2.val", sr, 8'h24);

    // set/clr priority
    flag_set = 8'h01; flag_clr = 8'h01; flag_mask = 8'h01; alu_sr = 8'h01;
    tick("clrwin");
    check("clrwin.c", sr & 8'h01, 8'h00);
    flag_set = 8'h04; tick("sei");
    check("sei.i", sr & 8'h04, 8'h04);
    flag_clr = 8'h04; tick("cli");
    check("cli.i", sr & 8'h04, 8'h00);

    // PLP
    plp_en = 1; alu_data = 8'h00; flag_set = 8'hFF; tick("plp0");
    check("plp0.sr", sr, 8'h20);
    check("plp0.push", sr_push, 8'h30);
    plp_en = 1; alu_data = 8'hFF; tick("plpf");
    check("plpf.sr", sr, 8'hEF);

    // idle hold
    tick("hold");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      alu_data  = 8'($urandom);
      alu_sr    = 8'($urandom) & 8'hC3;
      wr_en     = 1'($urandom);
      wr_sel    = 2'($urandom);
      flag_mask = 8'($urandom) & 8'($urandom);
      flag_set  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      flag_clr  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      plp_en    = ($urandom_range(0, 7) == 0);
      sp_inc    = 1'($urandom);
      sp_dec    = 1'($urandom);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
